// File: rtl/alu_pipe_nbit_if.sv
// Stream bundle for alu_pipe_nbit: operation in (valid/ready) and result/flags out (valid/ready).
interface alu_pipe_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic [7:0]       o_flag;

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_flag
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_flag
  );
endinterface

// File: rtl/alu_pipe_nbit.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready backpressure and 8-bit flag vector.
// Optional sticky overflow flag when ALU_STICKY_OVF_EN is defined.
module alu_pipe_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef ALU_STICKY_OVF_EN
  input  logic i_clr_sticky,
  output logic o_sticky_ovf,
`endif
  alu_pipe_nbit_if.slave bus
);

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [WIDTH:0]   s1_wide_q;
  logic [WIDTH:0]   s1_wide_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [7:0]       out_flag_q;
  logic [WIDTH-1:0] res_d;
  logic [7:0]       flag_d;

  logic s1_adv;
  logic s2_adv;

  // o_ready is combinational from i_ready: no skid buffer.
  assign s2_adv = !out_valid_q || bus.i_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  assign bus.o_ready  = s1_adv;
  assign bus.o_valid  = out_valid_q;
  assign bus.o_result = out_result_q;
  assign bus.o_flag   = out_flag_q;

  // Stage 1 arithmetic: bit WIDTH is carry-out for add, borrow for subtracts.
  always_comb begin
    s1_wide_d = '0;
    case (bus.i_op)
      3'd0:    s1_wide_d = {1'b0, bus.i_a} + {1'b0, bus.i_b};
      3'd2:    s1_wide_d = {1'b0, bus.i_b} - {1'b0, bus.i_a};
      default: s1_wide_d = {1'b0, bus.i_a} - {1'b0, bus.i_b};
    endcase
  end

  always_comb begin
    logic a_msb, b_msb, r_msb;
    logic c, v, eq, gt, lt;
    a_msb = s1_a_q[WIDTH-1];
    b_msb = s1_b_q[WIDTH-1];
    r_msb = s1_wide_q[WIDTH-1];
    res_d = '0;
    c     = 1'b0;
    v     = 1'b0;
    eq    = 1'b0;
    gt    = 1'b0;
    lt    = 1'b0;
    case (s1_op_q)
      3'd0: begin
        res_d = s1_wide_q[WIDTH-1:0];
        c     = s1_wide_q[WIDTH];
        v     = (a_msb == b_msb) && (r_msb != a_msb);
      end
      3'd1: begin
        res_d = s1_wide_q[WIDTH-1:0];
        c     = s1_wide_q[WIDTH];
        v     = (a_msb != b_msb) && (r_msb != a_msb);
      end
      3'd2: begin
        res_d = s1_wide_q[WIDTH-1:0];
        c     = s1_wide_q[WIDTH];
        v     = (a_msb != b_msb) && (r_msb != b_msb);
      end
      3'd3: res_d = s1_a_q & s1_b_q;
      3'd4: res_d = s1_a_q | s1_b_q;
      3'd5: res_d = s1_a_q ^ s1_b_q;
      3'd6: res_d = ~s1_a_q;
      3'd7: begin
        res_d = s1_wide_q[WIDTH-1:0];
        c     = s1_wide_q[WIDTH];
        v     = (a_msb != b_msb) && (r_msb != a_msb);
        eq    = (s1_a_q == s1_b_q);
        gt    = $signed(s1_a_q) > $signed(s1_b_q);
        lt    = $signed(s1_a_q) < $signed(s1_b_q);
      end
      default: res_d = '0;
    endcase
    flag_d = {1'b0, lt, gt, eq, res_d[WIDTH-1], v, c, (res_d == '0)};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_wide_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flag_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.i_valid;
        if (bus.i_valid) begin
          s1_op_q   <= bus.i_op;
          s1_a_q    <= bus.i_a;
          s1_b_q    <= bus.i_b;
          s1_wide_q <= s1_wide_d;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= res_d;
          out_flag_q   <= flag_d;
        end
      end
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  assign o_sticky_ovf = sticky_q;

  // Set has priority over clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_q <= 1'b0;
    end else if (out_valid_q && bus.i_ready && out_flag_q[2]) begin
      sticky_q <= 1'b1;
    end else if (i_clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end
`endif

endmodule
